if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage. Owns the fetch PC, issues word requests to the instruction memory over a req/gnt/rvalid interface, and buffers returned instructions with their PC in an in-order fetch queue. Presents one instruction per cycle to the decode stage with valid/ready flow control. Accepts redirects from branch/jump resolution and discards wrong-path responses still in flight.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset
FQ_DEPTH, 2, fetch-queue entries; also the limit on outstanding requests (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  redirect target; bits [1:0] ignored and treated as 00
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch word address, always 4-byte aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in request order
imem_rdata_i  input  32  response instruction
id_valid_o  output  1  instruction valid to decode
id_ready_i  input  1  decode accepts this cycle; low means decode stall
pc_o  output  32  PC of the presented instruction
pc_plus_4_o  output  32  pc_o + 4, modulo 2^32
instruction_o  output  32  presented instruction; 32'h00000013 (NOP) when id_valid_o=0

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC; queue empty; discard_cnt=0.
  - imem_req_o=0, id_valid_o=0, instruction_o=NOP, pc_o=0, pc_plus_4_o=0.
  - Reset mid-operation drops all entries. Responses to pre-reset requests arriving after reset are ignored, as are any unexpected responses.
- Fetch queue:
  - Each entry holds {pc, instr, filled}.
  - Entry allocated on a granted request (imem_req_o & imem_gnt_i), with pc=fetch_pc and filled=0.
  - imem_rvalid_i with discard_cnt=0 writes the oldest unfilled entry and sets filled=1.
  - Pop when id_valid_o & id_ready_i.
  - used = allocated entries.
- Request:
  - imem_req_o = !redirect_i && (used + discard_cnt < FQ_DEPTH).
  - imem_addr_o = fetch_pc.
  - On grant, fetch_pc += 4. imem_req_o/imem_addr_o stay stable until granted unless a redirect occurs.
- Output:
  - id_valid_o = head.filled && !redirect_i.
  - pc_o / instruction_o come from the head entry.
  - Data is registered, so there is no rvalid-to-output bypass. Granted at cycle T, rvalid at T+k (k>=1) gives id_valid_o at T+k+1 at the earliest.
  - While id_ready_i=0, all outputs hold stable.
- Redirect (redirect_i=1 at a posedge):
  - All entries are cleared; a pop in the same cycle is ignored.
  - fetch_pc = {redirect_pc_i[31:2],2'b00}.
  - discard_cnt_next = discard_cnt + unfilled_entries - (imem_rvalid_i ? 1 : 0). The same-cycle response counts as old-path.
  - While discard_cnt>0, each rvalid decrements discard_cnt and its data is dropped.
  - First new request is issued the cycle after the redirect.
- Simultaneous events:
  - Grant, fill and pop in one cycle are all legal and are applied together.
  - Full queue (used+discard_cnt=FQ_DEPTH) stops requests. Every issued request is therefore guaranteed a slot.
- Counters are sized for 0..FQ_DEPTH.
- Wrap-around: fetch_pc and pc_plus_4 wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).

Test Plan:
1. Reset with RESET_PC=0x0, gnt always 1, rvalid 1 cycle after grant, ready=1:
   - Requests at 0x0, 0x4, 0x8.
   - id_valid_o first high 2 cycles after the first grant.
   - Outputs: pc_o=0x0, pc_plus_4_o=0x4, instruction_o=mem[0].
   - Then one instruction per cycle.
   - Before that, instruction_o=0x00000013.
2. Hold id_ready_i=0 for 5 cycles with FQ_DEPTH=2:
   - At most 2 grants.
   - imem_req_o drops while used=2.
   - pc_o/instruction_o stay stable.
   - On release, instructions 0x0, 0x4 are delivered in order with no loss or duplication.
3. Two requests outstanding (0x8, 0xC), then redirect_i with redirect_pc_i=0x103:
   - Both later responses are dropped.
   - Next request address is 0x100.
   - First delivered pc_o=0x100 with the 0x100 data.
4. Redirect in the same cycle as rvalid for 0x8, with 0xC still outstanding:
   - discard_cnt=1.
   - Neither 0x8 nor 0xC data reaches decode.
   - id_valid_o=0 in the redirect cycle.
5. imem_gnt_i held 0 for 4 cycles:
   - imem_req_o=1 and imem_addr_o stable.
   - No allocation.
   - Fetch proceeds normally once gnt=1.
6. Redirect to 0xFFFFFFFC:
   - Requests at 0xFFFFFFFC, then 0x00000000.
   - For the first instruction: pc_o=0xFFFFFFFC, pc_plus_4_o=0x00000000.
   - Reset asserted mid-burst empties the queue; post-reset fetch starts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, issues imem word requests and queues responses in order for decode.
// Latency: grant at T, rvalid at T+k gives id_valid_o at T+k+1 at the earliest; a stall holds all outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic [31:0] instruction_o
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         pc_q    [FQ_DEPTH];
  logic [31:0]         instr_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] filled_q;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [CW-1:0]       used_q, used_d;
  logic [CW-1:0]       unfilled_q, unfilled_d;
  logic [CW-1:0]       discard_q, discard_d;

  logic          grant, fill, pop;
  logic [CW:0]   occupancy;
  logic [CW-1:0] stale_total;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Requests are throttled on slots already owed to in-flight responses, so every grant has a slot.
  assign occupancy   = {1'b0, used_q} + {1'b0, discard_q};
  assign imem_req_o  = rst_n && !redirect_i && (occupancy < (CW+1)'(FQ_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign fill        = imem_rvalid_i && (discard_q == '0) && (unfilled_q != '0);

  assign id_valid_o    = rst_n && filled_q[rd_ptr_q] && !redirect_i;
  assign pop           = id_valid_o && id_ready_i;
  assign pc_o          = pc_q[rd_ptr_q];
  assign pc_plus_4_o   = (used_q != '0) ? pc_o + 32'd4 : 32'd0;
  assign instruction_o = id_valid_o ? instr_q[rd_ptr_q] : NOP;

  assign stale_total = discard_q + unfilled_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    used_d     = used_q;
    unfilled_d = unfilled_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      used_d     = '0;
      unfilled_d = '0;
      // A response landing in the redirect cycle belongs to the old path.
      discard_d  = stale_total - CW'(imem_rvalid_i && (stale_total != '0));
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (fill) fill_ptr_d = fill_ptr_q + PW'(1);
      if (pop)  rd_ptr_d   = rd_ptr_q + PW'(1);
      if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
      used_d     = used_q + CW'(grant) - CW'(pop);
      unfilled_d = unfilled_q + CW'(grant) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      used_q     <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
      filled_q   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= NOP;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      used_q     <= used_d;
      unfilled_q <= unfilled_d;
      discard_q  <= discard_d;
      if (redirect_i) begin
        filled_q <= '0;
        for (int i = 0; i < FQ_DEPTH; i++) begin
          pc_q[i]    <= '0;
          instr_q[i] <= NOP;
        end
      end else begin
        if (grant) begin
          pc_q[wr_ptr_q]     <= fetch_pc_q;
          filled_q[wr_ptr_q] <= 1'b0;
        end
        if (fill) begin
          instr_q[fill_ptr_q]  <= imem_rdata_i;
          filled_q[fill_ptr_q] <= 1'b1;
        end
        if (pop) filled_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle in-order instruction memory model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;
  logic [31:0] instruction_o;

  if_stage #(.RESET_PC(32'h00000000), .FQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .pc_o(pc_o),
    .pc_plus_4_o(pc_plus_4_o), .instruction_o(instruction_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h00000013;

  int n_cmp = 0;
  int n_bad = 0;
  bit resp_en;
  logic [31:0] pend[$];
  logic [31:0] gr[$];
  logic [31:0] dp[$];
  logic [31:0] d4[$];
  logic [31:0] di[$];

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return 32'hC0DE0000 ^ a;
  endfunction

  task automatic clear_logs();
    gr.delete(); dp.delete(); d4.delete(); di.delete();
  endtask

  // One clock: log grants/deliveries before the edge, then drive the memory response for the next cycle.
  task automatic step();
    logic        g_now;
    logic [31:0] g_a;
    #1;
    g_now = imem_req_o && imem_gnt_i;
    g_a   = imem_addr_o;
    if (g_now) gr.push_back(g_a);
    if (id_valid_o && id_ready_i) begin
      dp.push_back(pc_o); d4.push_back(pc_plus_4_o); di.push_back(instruction_o);
    end
    @(posedge clk);
    #1;
    if (g_now) pend.push_back(g_a);
    if (resp_en && pend.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_of(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b1; id_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    resp_en = 1'b1;
    pend.delete();
    step(); step();
    pend.delete();
    imem_rvalid_i = 1'b0;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b1; id_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    resp_en = 1'b1;
    step(); step();
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    n_cmp++; if (instruction_o !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instruction_o, NOP); end
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    n_cmp++; if (pc_plus_4_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want 0", pc_plus_4_o); end
  endtask

  task automatic test_fetch();
    int bad;
    do_reset();
    #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL fetch_c0_req: got %b/%h want 1/0", imem_req_o, imem_addr_o); end
    n_cmp++; if (id_valid_o !== 1'b0 || instruction_o !== NOP) begin n_bad++; $display("FAIL fetch_c0_out: got %b/%h want 0/%h", id_valid_o, instruction_o, NOP); end
    step(); #1;
    n_cmp++; if (id_valid_o !== 1'b0 || instruction_o !== NOP) begin n_bad++; $display("FAIL fetch_c1_out: got %b/%h want 0/%h", id_valid_o, instruction_o, NOP); end
    n_cmp++; if (imem_addr_o !== 32'h4) begin n_bad++; $display("FAIL fetch_c1_addr: got %h want 4", imem_addr_o); end
    step(); #1;
    n_cmp++; if (id_valid_o !== 1'b1) begin n_bad++; $display("FAIL fetch_c2_valid: got %b want 1", id_valid_o); end
    n_cmp++; if (pc_o !== 32'h0 || pc_plus_4_o !== 32'h4 || instruction_o !== mem_of(32'h0)) begin n_bad++; $display("FAIL fetch_c2_data: got %h/%h/%h want 0/4/%h", pc_o, pc_plus_4_o, instruction_o, mem_of(32'h0)); end
    repeat (12) step();
    n_cmp++; if (gr.size() < 3 || gr[0] !== 32'h0 || gr[1] !== 32'h4 || gr[2] !== 32'h8) begin n_bad++; $display("FAIL fetch_req_seq: got %0d grants", gr.size()); end
    bad = 0;
    for (int i = 0; i < dp.size(); i++)
      if (dp[i] !== 32'(4*i) || d4[i] !== 32'(4*i+4) || di[i] !== mem_of(32'(4*i))) bad++;
    n_cmp++; if (dp.size() < 6 || bad != 0) begin n_bad++; $display("FAIL fetch_stream: got %0d delivered %0d wrong want >=6 in order", dp.size(), bad); end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    id_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i >= 2) begin
        n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_req_c%0d: got %b want 0", i, imem_req_o); end
        n_cmp++; if (id_valid_o !== 1'b1 || pc_o !== 32'h0 || instruction_o !== mem_of(32'h0)) begin n_bad++; $display("FAIL stall_hold_c%0d: got %b/%h/%h want 1/0/%h", i, id_valid_o, pc_o, instruction_o, mem_of(32'h0)); end
      end
      step();
    end
    n_cmp++; if (gr.size() != 2 || dp.size() != 0) begin n_bad++; $display("FAIL stall_grants: got %0d grants %0d pops want 2/0", gr.size(), dp.size()); end
    id_ready_i = 1'b1;
    repeat (8) step();
    bad = 0;
    for (int i = 0; i < dp.size(); i++) if (dp[i] !== 32'(4*i) || di[i] !== mem_of(32'(4*i))) bad++;
    n_cmp++; if (dp.size() < 3 || bad != 0) begin n_bad++; $display("FAIL stall_release: got %0d delivered %0d wrong want 0,4,8.. in order", dp.size(), bad); end
  endtask

  task automatic test_redirect();
    int bad;
    do_reset();
    step(); step(); step();
    resp_en = 1'b0;
    step(); step();
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL redir_full: got %b want 0", imem_req_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h00000103; resp_en = 1'b1;
    #1;
    n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL redir_valid: got %b want 0", id_valid_o); end
    clear_logs();
    step();
    redirect_i = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h100) begin n_bad++; $display("FAIL redir_c1: got %b/%h want 0/100", imem_req_o, imem_addr_o); end
    step(); #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_bad++; $display("FAIL redir_c2: got %b/%h want 1/100", imem_req_o, imem_addr_o); end
    repeat (8) step();
    n_cmp++; if (gr.size() < 1 || gr[0] !== 32'h100) begin n_bad++; $display("FAIL redir_first_req: got %0d grants want first 100", gr.size()); end
    bad = 0;
    for (int i = 0; i < dp.size(); i++) if (dp[i] == 32'h8 || dp[i] == 32'hC) bad++;
    n_cmp++; if (dp.size() < 1 || dp[0] !== 32'h100 || di[0] !== mem_of(32'h100) || bad != 0) begin n_bad++; $display("FAIL redir_delivery: got %0d delivered %0d stale want first pc 100", dp.size(), bad); end
  endtask

  task automatic test_redirect_rvalid();
    int bad;
    do_reset();
    step(); step(); step();
    resp_en = 1'b0;
    step();
    resp_en = 1'b1;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h00000200;
    #1;
    n_cmp++; if (imem_rvalid_i !== 1'b1 || id_valid_o !== 1'b0) begin n_bad++; $display("FAIL rvredir_cycle: got rvalid %b valid %b want 1/0", imem_rvalid_i, id_valid_o); end
    clear_logs();
    step();
    redirect_i = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_bad++; $display("FAIL rvredir_discard1: got %b/%h want 1/200", imem_req_o, imem_addr_o); end
    repeat (8) step();
    n_cmp++; if (gr.size() < 1 || gr[0] !== 32'h200) begin n_bad++; $display("FAIL rvredir_first_req: got %0d grants want first 200", gr.size()); end
    bad = 0;
    for (int i = 0; i < dp.size(); i++) if (dp[i] == 32'h8 || dp[i] == 32'hC || di[i] == mem_of(32'h8) || di[i] == mem_of(32'hC)) bad++;
    n_cmp++; if (dp.size() < 1 || dp[0] !== 32'h200 || di[0] !== mem_of(32'h200) || bad != 0) begin n_bad++; $display("FAIL rvredir_delivery: got %0d delivered %0d stale want first pc 200", dp.size(), bad); end
  endtask

  task automatic test_no_gnt();
    do_reset();
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL nognt_c%0d: got %b/%h want 1/0", i, imem_req_o, imem_addr_o); end
      step();
    end
    n_cmp++; if (gr.size() != 0 || id_valid_o !== 1'b0) begin n_bad++; $display("FAIL nognt_alloc: got %0d grants valid %b want 0/0", gr.size(), id_valid_o); end
    imem_gnt_i = 1'b1;
    repeat (8) step();
    n_cmp++; if (dp.size() < 2 || dp[0] !== 32'h0 || dp[1] !== 32'h4 || di[1] !== mem_of(32'h4)) begin n_bad++; $display("FAIL nognt_resume: got %0d delivered want 0,4", dp.size()); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
    step();
    redirect_i = 1'b0;
    repeat (10) step();
    n_cmp++; if (gr.size() < 2 || gr[0] !== 32'hFFFFFFFC || gr[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_req: got %0d grants want FFFFFFFC,0", gr.size()); end
    n_cmp++; if (dp.size() < 2 || dp[0] !== 32'hFFFFFFFC || d4[0] !== 32'h0 || di[0] !== mem_of(32'hFFFFFFFC)) begin n_bad++; $display("FAIL wrap_first: got %0d delivered want pc FFFFFFFC pc4 0", dp.size()); end
    n_cmp++; if (dp.size() < 2 || dp[1] !== 32'h0 || d4[1] !== 32'h4) begin n_bad++; $display("FAIL wrap_second: got %0d delivered want pc 0 pc4 4", dp.size()); end
    resp_en = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    #1;
    n_cmp++; if (id_valid_o !== 1'b0 || instruction_o !== NOP || imem_req_o !== 1'b0) begin n_bad++; $display("FAIL midreset_out: got %b/%h/%b want 0/%h/0", id_valid_o, instruction_o, imem_req_o, NOP); end
    rst_n = 1'b1;
    pend.delete();
    resp_en = 1'b1;
    clear_logs();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEADBEEF;
    #1;
    n_cmp++; if (id_valid_o !== 1'b0 || pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL postreset_c0: got %b/%h/%h want 0/0/0", id_valid_o, pc_o, imem_addr_o); end
    repeat (8) step();
    n_cmp++; if (gr.size() < 1 || gr[0] !== 32'h0 || dp.size() < 1 || dp[0] !== 32'h0 || di[0] !== mem_of(32'h0)) begin n_bad++; $display("FAIL postreset_fetch: got %0d grants %0d delivered want pc 0 data %h", gr.size(), dp.size(), mem_of(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_no_gnt();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
